// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction line-fetch stage.
//   fetch_state_t : fetch controller states
//   LINE_BYTES    : bytes per cached line (one 8-beat burst of 8 bytes)
//   AXI_*         : fixed AR-channel attributes for a line burst
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ,
    FILL,
    DRAIN,
    HALT
  } fetch_state_t;

  localparam int         LINE_BYTES     = 64;
  localparam logic [2:0] AXI_ARSIZE_8B  = 3'd3;
  localparam logic [1:0] AXI_BURST_INCR = 2'd1;
  localparam logic [7:0] AXI_ARLEN_LINE = 8'd7;

endpackage

// File: rtl/fetch_line_buf.sv
// One-line instruction buffer: 8 x 64-bit beats, viewed as 16 x 32-bit words.
//   clk    : clock
//   we     : write enable for one beat
//   widx   : beat index written (0..7)
//   wdata  : beat data; wdata[31:0] is the lower-addressed word
//   slot   : 32-bit word index to read (0..15)
//   rword  : combinational read of the selected word
module fetch_line_buf (
  input  logic        clk,
  input  logic        we,
  input  logic [2:0]  widx,
  input  logic [63:0] wdata,
  input  logic [3:0]  slot,
  output logic [31:0] rword
);

  logic [63:0] mem [8];
  logic [63:0] beat_sel;

  // Storage carries no reset: contents are only read after a full fill.
  always_ff @(posedge clk) begin
    if (we) mem[widx] <= wdata;
  end

  // Slot 2k lives in the low half of beat k, slot 2k+1 in the high half.
  always_comb begin
    beat_sel = mem[slot[3:1]];
    rword    = slot[0] ? beat_sel[63:32] : beat_sel[31:0];
  end

endmodule

// File: rtl/insn_line_fetch.sv
// AXI4 read-master instruction fetch stage.
// Fetches one 64-byte line per 8-beat INCR burst into a local buffer and
// hands it out as 32-bit instructions with their PCs on a valid/ready port.
//   clk, reset        : clock, synchronous active-low reset
//   entry_pc          : start PC, loaded while reset is low
//   redirect_valid/pc : restart fetch at a new 4-byte aligned PC
//   m_axi_ar*         : AR channel (one line burst at a time)
//   m_axi_r*          : R channel (rid ignored, rresp != 0 is an error)
//   insn_valid/ready  : instruction handshake to the decoder
//   insn, insn_pc     : presented instruction and its address
//   halted            : sticky, an all-zero instruction word was reached
//   fault             : sticky, bus error or malformed burst
module insn_line_fetch
  import fetch_pkg::*;
#(
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int BEATS      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] entry_pc,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic                  insn_valid,
  input  logic                  insn_ready,
  output logic [31:0]           insn,
  output logic [ADDR_WIDTH-1:0] insn_pc,
  output logic                  halted,
  output logic                  fault
);

  localparam int                    OFS_W     = $clog2(LINE_BYTES);
  localparam logic [2:0]            LAST_BEAT = 3'(BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP   = ADDR_WIDTH'(4);

  fetch_state_t          state, state_n;
  logic [ADDR_WIDTH-1:0] pc, pc_n, pc_inc;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_n;
  logic [ADDR_WIDTH-1:0] insn_pc_q, insn_pc_n;
  logic [31:0]           insn_q, insn_n, buf_word;
  logic [2:0]            beat_cnt, beat_cnt_n;
  logic                  drop_line, drop_line_n;
  logic                  arvalid_q, arvalid_n;
  logic                  insn_valid_q, insn_valid_n;
  logic                  halted_q, halted_n;
  logic                  fault_q, fault_n;
  logic                  insn_fire, beat_fire, beat_bad;
  logic [3:0]            rd_slot;
  logic                  unused_rid;

  assign unused_rid = ^m_axi_rid;

  assign pc_inc    = pc + PC_STEP;
  assign insn_fire = insn_valid_q && insn_ready;
  assign beat_fire = (state == FILL) && m_axi_rvalid;
  // A beat is malformed if rlast does not coincide exactly with the last beat.
  assign beat_bad  = (m_axi_rresp != 2'b00) || (m_axi_rlast != (beat_cnt == LAST_BEAT));
  // Look ahead to the next slot when the current word is being accepted so
  // the decoder sees one instruction per cycle.
  assign rd_slot   = insn_fire ? pc_inc[5:2] : pc[5:2];

  fetch_line_buf u_buf (
    .clk   (clk),
    .we    (beat_fire),
    .widx  (beat_cnt),
    .wdata (m_axi_rdata),
    .slot  (rd_slot),
    .rword (buf_word)
  );

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    araddr_n     = araddr_q;
    insn_pc_n    = insn_pc_q;
    insn_n       = insn_q;
    beat_cnt_n   = beat_cnt;
    drop_line_n  = drop_line;
    arvalid_n    = arvalid_q;
    insn_valid_n = insn_valid_q;
    halted_n     = halted_q;
    fault_n      = fault_q;

    case (state)
      REQ: begin
        if (redirect_valid) pc_n = redirect_pc;
        if (!arvalid_q) begin
          // Address is captured once and held until the handshake.
          arvalid_n = 1'b1;
          araddr_n  = {pc_n[ADDR_WIDTH-1:OFS_W], {OFS_W{1'b0}}};
        end else begin
          // Address already offered: let that burst run and throw it away.
          if (redirect_valid) drop_line_n = 1'b1;
          if (m_axi_arready) begin
            arvalid_n  = 1'b0;
            beat_cnt_n = 3'd0;
            state_n    = FILL;
          end
        end
      end

      FILL: begin
        if (redirect_valid) begin
          pc_n        = redirect_pc;
          drop_line_n = 1'b1;
        end
        if (m_axi_rvalid) begin
          if (beat_bad) begin
            fault_n = 1'b1;
            state_n = HALT;
          end else if (m_axi_rlast) begin
            beat_cnt_n  = 3'd0;
            drop_line_n = 1'b0;
            state_n     = (drop_line || redirect_valid) ? REQ : DRAIN;
          end else begin
            beat_cnt_n = beat_cnt + 3'd1;
          end
        end
      end

      DRAIN: begin
        if (redirect_valid) begin
          pc_n         = redirect_pc;
          insn_valid_n = 1'b0;
          state_n      = REQ;
        end else if (insn_fire && (pc[5:2] == 4'hF)) begin
          pc_n         = pc_inc;
          insn_valid_n = 1'b0;
          state_n      = REQ;
        end else if (!insn_valid_q || insn_fire) begin
          if (insn_fire) pc_n = pc_inc;
          if (buf_word == 32'h0) begin
            insn_valid_n = 1'b0;
            halted_n     = 1'b1;
            state_n      = HALT;
          end else begin
            insn_valid_n = 1'b1;
            insn_n       = buf_word;
            insn_pc_n    = pc_n;
          end
        end
      end

      HALT: begin
        arvalid_n    = 1'b0;
        insn_valid_n = 1'b0;
      end

      default: state_n = HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= REQ;
      pc           <= entry_pc;
      beat_cnt     <= 3'd0;
      drop_line    <= 1'b0;
      arvalid_q    <= 1'b0;
      insn_valid_q <= 1'b0;
      halted_q     <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state        <= state_n;
      pc           <= pc_n;
      beat_cnt     <= beat_cnt_n;
      drop_line    <= drop_line_n;
      arvalid_q    <= arvalid_n;
      insn_valid_q <= insn_valid_n;
      halted_q     <= halted_n;
      fault_q      <= fault_n;
    end
  end

  // Data registers are qualified by their valids and need no reset.
  always_ff @(posedge clk) begin
    araddr_q  <= araddr_n;
    insn_q    <= insn_n;
    insn_pc_q <= insn_pc_n;
  end

  assign m_axi_arid    = '0;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arlen   = AXI_ARLEN_LINE;
  assign m_axi_arsize  = AXI_ARSIZE_8B;
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = (state == FILL);
  assign insn_valid    = insn_valid_q;
  assign insn          = insn_q;
  assign insn_pc       = insn_pc_q;
  assign halted        = halted_q;
  assign fault         = fault_q;

endmodule

// File: tb/tb_insn_line_fetch.sv
// Scoreboard bench for insn_line_fetch: the stimulus process queues the
// expected AR addresses and instructions, a monitor pops and compares them
// whenever the DUT performs an AR or instruction handshake.
module tb_insn_line_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] entry_pc;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic [12:0] m_axi_arid;
  logic [63:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [12:0] m_axi_rid;
  logic [63:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast;
  logic        m_axi_rvalid;
  logic        m_axi_rready;
  logic        insn_valid;
  logic        insn_ready;
  logic [31:0] insn;
  logic [63:0] insn_pc;
  logic        halted;
  logic        fault;

  always #5 clk = ~clk;

  insn_line_fetch dut (
    .clk            (clk),
    .reset          (reset),
    .entry_pc       (entry_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .m_axi_arid     (m_axi_arid),
    .m_axi_araddr   (m_axi_araddr),
    .m_axi_arlen    (m_axi_arlen),
    .m_axi_arsize   (m_axi_arsize),
    .m_axi_arburst  (m_axi_arburst),
    .m_axi_arvalid  (m_axi_arvalid),
    .m_axi_arready  (m_axi_arready),
    .m_axi_rid      (m_axi_rid),
    .m_axi_rdata    (m_axi_rdata),
    .m_axi_rresp    (m_axi_rresp),
    .m_axi_rlast    (m_axi_rlast),
    .m_axi_rvalid   (m_axi_rvalid),
    .m_axi_rready   (m_axi_rready),
    .insn_valid     (insn_valid),
    .insn_ready     (insn_ready),
    .insn           (insn),
    .insn_pc        (insn_pc),
    .halted         (halted),
    .fault          (fault)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [31:0] exp_insn_q [$];
  logic [63:0] exp_pc_q   [$];
  logic [63:0] exp_ar_q   [$];
  logic [31:0] line_w     [16];

  bit          tog_mode   = 1'b0;
  int          last_fire  = -1;
  int          fire_cnt   = 0;
  bit          stall_seen = 1'b0;
  logic [31:0] stall_insn;
  logic [63:0] stall_pc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got no event within bound, expected one", name);
  endtask

  // Decoder-side ready: constant 1, or alternating each cycle.
  initial begin
    insn_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      insn_ready = tog_mode ? ~insn_ready : 1'b1;
    end
  end

  // Monitor: compares every handshake against the queued expectations.
  always @(negedge clk) begin
    if (!reset) begin
      stall_seen = 1'b0;
    end else begin
      if (m_axi_arvalid && m_axi_arready) begin
        if (exp_ar_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL ar_unexpected: got araddr 0x%0h, expected no request", m_axi_araddr);
        end else begin
          check("araddr", m_axi_araddr, exp_ar_q.pop_front());
          check("arlen", 64'(m_axi_arlen), 64'd7);
          check("arsize", 64'(m_axi_arsize), 64'd3);
          check("arburst", 64'(m_axi_arburst), 64'd1);
          check("arid", 64'(m_axi_arid), 64'd0);
        end
      end
      if (stall_seen) begin
        check("stall_valid", 64'(insn_valid), 64'd1);
        check("stall_insn", 64'(insn), 64'(stall_insn));
        check("stall_pc", insn_pc, stall_pc);
      end
      stall_seen = insn_valid && !insn_ready;
      stall_insn = insn;
      stall_pc   = insn_pc;
      if (insn_valid && insn_ready) begin
        if (exp_insn_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL insn_unexpected: got insn 0x%0h pc 0x%0h, expected none", insn, insn_pc);
        end else begin
          check("insn", 64'(insn), 64'(exp_insn_q.pop_front()));
          check("insn_pc", insn_pc, exp_pc_q.pop_front());
        end
        if (tog_mode && last_fire >= 0) check("fire_spacing", 64'(cyc - last_fire), 64'd2);
        last_fire = cyc;
        fire_cnt++;
      end
    end
  end

  task automatic do_reset(input logic [63:0] epc);
    reset          = 1'b0;
    entry_pc       = epc;
    redirect_valid = 1'b0;
    m_axi_rvalid   = 1'b0;
    m_axi_rlast    = 1'b0;
    m_axi_rresp    = 2'b00;
    m_axi_arready  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
    check("rst_rready", 64'(m_axi_rready), 64'd0);
    check("rst_insn_valid", 64'(insn_valid), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_fault", 64'(fault), 64'd0);
    reset = 1'b1;
  endtask

  task automatic wait_ar(input string name);
    int n = 0;
    while (!(m_axi_arvalid && m_axi_arready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) fail_evt(name);
    @(negedge clk);
  endtask

  // Returns one line from line_w; optional error beat and redirect beat.
  task automatic send_line(input int err_beat, input int redir_beat, input logic [63:0] rpc);
    for (int k = 0; k < 8; k++) begin
      m_axi_rvalid   = 1'b1;
      m_axi_rdata    = {line_w[2*k+1], line_w[2*k]};
      m_axi_rlast    = (k == 7);
      m_axi_rresp    = (k == err_beat) ? 2'b10 : 2'b00;
      redirect_valid = (k == redir_beat);
      redirect_pc    = rpc;
      @(negedge clk);
      if (k == err_beat) break;
    end
    m_axi_rvalid   = 1'b0;
    m_axi_rlast    = 1'b0;
    m_axi_rresp    = 2'b00;
    redirect_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_insn_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) fail_evt(name);
  endtask

  task automatic push_insns(input logic [63:0] line_base, input int first, input int last);
    for (int s = first; s <= last; s++) begin
      exp_insn_q.push_back(line_w[s]);
      exp_pc_q.push_back(line_base + 64'(4 * s));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; entry_pc = '0; redirect_valid = 1'b0; redirect_pc = '0;
    m_axi_arready = 1'b0; m_axi_rid = '0; m_axi_rdata = '0;
    m_axi_rresp = 2'b00; m_axi_rlast = 1'b0; m_axi_rvalid = 1'b0;
    @(negedge clk);

    // Basic line: 16 nops from 0x1000, then the next line request.
    for (int i = 0; i < 16; i++) line_w[i] = 32'h0000_0013;
    do_reset(64'h1000);
    exp_ar_q.push_back(64'h1000);
    push_insns(64'h1000, 0, 15);
    exp_ar_q.push_back(64'h1040);
    wait_ar("t1_ar0");
    send_line(-1, -1, 64'h0);
    wait_drain("t1_drain");
    wait_ar("t1_ar1");

    // Mid-line entry: only slots 14 and 15 are presented.
    for (int i = 0; i < 16; i++) line_w[i] = 32'hA000_0000 + 32'(i);
    do_reset(64'h1038);
    exp_ar_q.push_back(64'h1000);
    push_insns(64'h1000, 14, 15);
    exp_ar_q.push_back(64'h1040);
    wait_ar("t2_ar0");
    send_line(-1, -1, 64'h0);
    wait_drain("t2_drain");
    wait_ar("t2_ar1");

    // Alternating decoder ready: stable while stalled, one fire per 2 cycles.
    for (int i = 0; i < 16; i++) line_w[i] = 32'hB000_0100 + 32'(i * 17);
    do_reset(64'h4000);
    exp_ar_q.push_back(64'h4000);
    push_insns(64'h4000, 0, 15);
    exp_ar_q.push_back(64'h4040);
    wait_ar("t3_ar0");
    last_fire = -1;
    fire_cnt  = 0;
    tog_mode  = 1'b1;
    send_line(-1, -1, 64'h0);
    wait_drain("t3_drain");
    wait_ar("t3_ar1");
    tog_mode = 1'b0;
    check("t3_fire_count", 64'(fire_cnt), 64'd16);

    // Zero word in beat 3 low half (slot 6): slots 0-5 then halt.
    for (int i = 0; i < 16; i++) line_w[i] = 32'hC000_0000 + 32'(i);
    line_w[6] = 32'h0;
    do_reset(64'h3000);
    exp_ar_q.push_back(64'h3000);
    push_insns(64'h3000, 0, 5);
    wait_ar("t4_ar0");
    send_line(-1, -1, 64'h0);
    wait_drain("t4_drain");
    repeat (2) @(negedge clk);
    check("t4_halted", 64'(halted), 64'd1);
    check("t4_insn_valid", 64'(insn_valid), 64'd0);
    check("t4_fault", 64'(fault), 64'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h5000;
    @(negedge clk);
    redirect_valid = 1'b0;
    repeat (20) @(negedge clk);
    check("t4_halted_sticky", 64'(halted), 64'd1);
    check("t4_no_ar", 64'(m_axi_arvalid), 64'd0);
    check("t4_no_insn", 64'(insn_valid), 64'd0);

    // Redirect during fill beat 2: rest of burst dropped, refetch 0x2000.
    for (int i = 0; i < 16; i++) line_w[i] = 32'hD000_0000 + 32'(i);
    do_reset(64'h1000);
    exp_ar_q.push_back(64'h1000);
    wait_ar("t5_ar0");
    exp_ar_q.push_back(64'h2000);
    send_line(-1, 2, 64'h2004);
    for (int i = 0; i < 16; i++) line_w[i] = 32'hE000_0000 + 32'(i);
    push_insns(64'h2000, 1, 15);
    exp_ar_q.push_back(64'h2040);
    wait_ar("t5_ar1");
    send_line(-1, -1, 64'h0);
    wait_drain("t5_drain");
    wait_ar("t5_ar2");
    check("t5_fault", 64'(fault), 64'd0);
    check("t5_halted", 64'(halted), 64'd0);

    // Bus error on beat 5: fault, nothing presented, no further requests.
    for (int i = 0; i < 16; i++) line_w[i] = 32'hF000_0000 + 32'(i);
    do_reset(64'h6000);
    exp_ar_q.push_back(64'h6000);
    wait_ar("t6_ar0");
    send_line(5, -1, 64'h0);
    @(negedge clk);
    check("t6_fault", 64'(fault), 64'd1);
    check("t6_halted", 64'(halted), 64'd0);
    check("t6_insn_valid", 64'(insn_valid), 64'd0);
    check("t6_rready", 64'(m_axi_rready), 64'd0);
    repeat (20) @(negedge clk);
    check("t6_no_ar", 64'(m_axi_arvalid), 64'd0);
    check("t6_fault_sticky", 64'(fault), 64'd1);

    // Reset clears the sticky fault.
    do_reset(64'h0);
    check("end_ar_queue", 64'(exp_ar_q.size()), 64'd0);
    check("end_insn_queue", 64'(exp_insn_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
